// File: rtl/prog_mem_arbiter.sv
// prog_mem_arbiter
//
// Shares one single-port microinstruction RAM (registered read, one-cycle
// read latency) between the CPU fetch unit and the program loader.
//
// Arbitration is combinational from the current-cycle requests. At most one
// RAM access is made per cycle.
// - With cpu_halt=0, fetch has priority until the loader has waited
//   STARVE_LIMIT cycles.
// - With cpu_halt=1, the loader always wins.
// Read data is routed back one cycle later using a registered owner tag.
//
// Optional build macro: PMEM_CLEAR_ON_RESET_EN
//   When it is defined, the block runs an INIT sweep after reset. The sweep
//   writes 0 to every RAM word, one per cycle, while busy=1. When it is not
//   defined, the block goes straight to RUN and busy is tied low.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   cpu_halt                    loader gets absolute priority
//   fetch_req/fetch_addr        fetch read request
//   fetch_stall                 fetch not issued this cycle
//   fetch_valid/fetch_data      fetch read return (data holds when not valid)
//   ld_req/ld_we/ld_addr/ld_wdata  loader request (held until ld_gnt)
//   ld_gnt                      loader request accepted this cycle
//   ld_rvalid/ld_rdata          loader read return (data holds when not valid)
//   ld_err                      pulse: accepted loader access was out of range
//   busy                        clear sweep in progress
//   ram_wr_enb/ram_rd_enb/ram_addr/ram_data_in/ram_data_out  RAM port
module prog_mem_arbiter #(
  parameter int RAM_WIDTH    = 22,
  parameter int RAM_DEPTH    = 1024,
  parameter int ADDR_SIZE    = 11,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cpu_halt,
  input  logic                 fetch_req,
  input  logic [ADDR_SIZE-1:0] fetch_addr,
  output logic                 fetch_stall,
  output logic                 fetch_valid,
  output logic [RAM_WIDTH-1:0] fetch_data,
  input  logic                 ld_req,
  input  logic                 ld_we,
  input  logic [ADDR_SIZE-1:0] ld_addr,
  input  logic [RAM_WIDTH-1:0] ld_wdata,
  output logic                 ld_gnt,
  output logic                 ld_rvalid,
  output logic [RAM_WIDTH-1:0] ld_rdata,
  output logic                 ld_err,
  output logic                 busy,
  output logic                 ram_wr_enb,
  output logic                 ram_rd_enb,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [RAM_WIDTH-1:0] ram_data_in,
  input  logic [RAM_WIDTH-1:0] ram_data_out
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;
  // Which requester owns the read data coming back from the RAM this cycle.
  // OWN_LD_ERR means an out-of-range loader read: it returns 0 and does not
  // touch the RAM.
  typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_LD, OWN_LD_ERR} owner_t;

  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

`ifdef PMEM_CLEAR_ON_RESET_EN
  localparam state_t RESET_STATE = ST_INIT;
`else
  localparam state_t RESET_STATE = ST_RUN;
`endif

  state_t               state_reg, state_next;
  owner_t               owner_reg, owner_next;
  logic [7:0]           starve_reg, starve_next;
  logic                 ld_err_reg, ld_err_next;
  logic [RAM_WIDTH-1:0] fetch_hold_reg, ld_hold_reg;

  logic                 ld_win, fetch_win, ld_bad;
  logic [31:0]          ld_addr_ext;

  assign ld_addr_ext = 32'(ld_addr);
  assign ld_bad      = (ld_addr_ext >= 32'(RAM_DEPTH));

`ifdef PMEM_CLEAR_ON_RESET_EN
  logic [ADDR_SIZE-1:0] init_addr_reg, init_addr_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_addr_reg <= '0;
    end else begin
      init_addr_reg <= init_addr_next;
    end
  end

  assign busy = (state_reg == ST_INIT);
`else
  assign busy = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= RESET_STATE;
      owner_reg      <= OWN_NONE;
      starve_reg     <= '0;
      ld_err_reg     <= 1'b0;
      fetch_hold_reg <= '0;
      ld_hold_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      starve_reg     <= starve_next;
      ld_err_reg     <= ld_err_next;
      fetch_hold_reg <= fetch_data;
      ld_hold_reg    <= ld_rdata;
    end
  end

  always_comb begin
    state_next  = state_reg;
    owner_next  = OWN_NONE;
    starve_next = starve_reg;
    ld_err_next = 1'b0;
    ld_win      = 1'b0;
    fetch_win   = 1'b0;
    fetch_stall = busy;
    ld_gnt      = 1'b0;
    ram_wr_enb  = 1'b0;
    ram_rd_enb  = 1'b0;
    ram_addr    = '0;
    ram_data_in = '0;
`ifdef PMEM_CLEAR_ON_RESET_EN
    init_addr_next = init_addr_reg;
`endif
    // While reset is held, every combinational output stays quiet.
    if (rst_n) begin
      case (state_reg)
`ifdef PMEM_CLEAR_ON_RESET_EN
        ST_INIT: begin
          ram_wr_enb     = 1'b1;
          ram_addr       = init_addr_reg;
          init_addr_next = init_addr_reg + 1'b1;
          if (init_addr_reg == ADDR_SIZE'(RAM_DEPTH - 1)) begin
            state_next     = ST_RUN;
            init_addr_next = '0;
          end
        end
`endif
        ST_RUN: begin
          ld_win    = ld_req && (cpu_halt || !fetch_req || (starve_reg >= STARVE_MAX));
          fetch_win = fetch_req && !ld_win;

          fetch_stall = fetch_req && !fetch_win;
          ld_gnt      = ld_win;

          if (fetch_win) begin
            ram_rd_enb = 1'b1;
            ram_addr   = fetch_addr;
            owner_next = OWN_FETCH;
          end else if (ld_win) begin
            // Out-of-range accesses still complete the handshake but never
            // reach the RAM.
            ram_addr    = ld_addr;
            ram_data_in = ld_wdata;
            ram_wr_enb  = ld_we && !ld_bad;
            ram_rd_enb  = !ld_we && !ld_bad;
            ld_err_next = ld_bad;
            if (!ld_we) begin
              owner_next = ld_bad ? OWN_LD_ERR : OWN_LD;
            end
          end

          if (ld_win) begin
            starve_next = '0;
          end else if (ld_req && (starve_reg < STARVE_MAX)) begin
            starve_next = starve_reg + 8'd1;
          end
        end
        default: begin
          state_next = RESET_STATE;
        end
      endcase
    end
  end

  // Return path: data passes straight from the RAM in the valid cycle.
  // Otherwise the last delivered word is held.
  assign fetch_valid = (owner_reg == OWN_FETCH);
  assign fetch_data  = fetch_valid ? ram_data_out : fetch_hold_reg;

  assign ld_rvalid = (owner_reg == OWN_LD) || (owner_reg == OWN_LD_ERR);
  assign ld_rdata  = (owner_reg == OWN_LD)     ? ram_data_out :
                     (owner_reg == OWN_LD_ERR) ? '0 : ld_hold_reg;
  assign ld_err    = ld_err_reg;

endmodule

// File: tb/tb_prog_mem_arbiter.sv
module tb_prog_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_halt;
  logic        fetch_req;
  logic [10:0] fetch_addr;
  logic        fetch_stall;
  logic        fetch_valid;
  logic [21:0] fetch_data;
  logic        ld_req;
  logic        ld_we;
  logic [10:0] ld_addr;
  logic [21:0] ld_wdata;
  logic        ld_gnt;
  logic        ld_rvalid;
  logic [21:0] ld_rdata;
  logic        ld_err;
  logic        busy;
  logic        ram_wr_enb;
  logic        ram_rd_enb;
  logic [10:0] ram_addr;
  logic [21:0] ram_data_in;
  logic [21:0] ram_data_out = '0;

  int total = 0;
  int bad   = 0;

`ifdef PMEM_CLEAR_ON_RESET_EN
  localparam logic SWEEP = 1'b1;
`else
  localparam logic SWEEP = 1'b0;
`endif

  always #5 clk = ~clk;

  prog_mem_arbiter #(
    .RAM_WIDTH(22), .RAM_DEPTH(1024), .ADDR_SIZE(11), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cpu_halt(cpu_halt),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_stall(fetch_stall),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata), .ld_err(ld_err),
    .busy(busy), .ram_wr_enb(ram_wr_enb), .ram_rd_enb(ram_rd_enb),
    .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  // Behavioural single-port RAM with registered read
  logic [21:0] mem [0:1023];
  always @(posedge clk) begin
    if (ram_wr_enb) mem[ram_addr[9:0]] = ram_data_in;
    if (ram_rd_enb) ram_data_out <= mem[ram_addr[9:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // One cycle: inputs change just after the falling edge, outputs are
  // sampled 1 time unit later, well before the next rising edge.
  task automatic drive(input logic fr, input logic [10:0] fa, input logic lr,
                       input logic lw, input logic [10:0] la, input logic [21:0] ldat,
                       input logic halt);
    @(negedge clk);
    fetch_req = fr; fetch_addr = fa;
    ld_req = lr; ld_we = lw; ld_addr = la; ld_wdata = ldat;
    cpu_halt = halt;
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; cpu_halt = 1'b0;
    fetch_req = 1'b1; fetch_addr = 11'd3;
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 11'd7; ld_wdata = 22'h3ffff;
    for (int a = 0; a < 1024; a++) mem[a] = 22'h3fffff;

    // Reset state, with requests asserted to show the outputs stay quiet
    repeat (2) @(negedge clk);
    #1;
    check("rst_fetch_valid", 32'(fetch_valid), 32'(0));
    check("rst_ld_rvalid",   32'(ld_rvalid),   32'(0));
    check("rst_ld_err",      32'(ld_err),      32'(0));
    check("rst_fetch_data",  32'(fetch_data),  32'(0));
    check("rst_ld_rdata",    32'(ld_rdata),    32'(0));
    check("rst_ld_gnt",      32'(ld_gnt),      32'(0));
    check("rst_ram_wr",      32'(ram_wr_enb),  32'(0));
    check("rst_ram_rd",      32'(ram_rd_enb),  32'(0));
    check("rst_busy",        32'(busy),        32'(SWEEP));
    check("rst_fetch_stall", 32'(fetch_stall), 32'(SWEEP));

    fetch_req = 1'b0; ld_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;

`ifdef PMEM_CLEAR_ON_RESET_EN
    begin
      int n;
      int nz;
      repeat (300) @(negedge clk);
      #1;
      check("sweep_addr300", 32'(ram_addr), 32'(300));
      check("sweep_wr300",   32'(ram_wr_enb), 32'(1));
      rst_n = 1'b0;
      #1;
      check("sweep_rst_wr",   32'(ram_wr_enb), 32'(0));
      check("sweep_rst_busy", 32'(busy), 32'(1));
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("sweep_restart_addr", 32'(ram_addr), 32'(0));
      n = 0;
      while (busy && n < 2000) begin
        n++;
        @(negedge clk);
        #1;
      end
      check("sweep_busy_cycles", 32'(n), 32'(1024));
      nz = 0;
      for (int a = 0; a < 1024; a++) if (mem[a] != 22'h0) nz++;
      check("sweep_nonzero_words", 32'(nz), 32'(0));
    end
`endif

    for (int a = 0; a < 4; a++) mem[a] = 22'h00200;
    mem[10] = 22'h2abcd;

    // Fetch-only stream 0..3
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 11'(k), 1'b0, 1'b0, 11'd0, 22'h0, 1'b0);
      check("fs_stall", 32'(fetch_stall), 32'(0));
      check("fs_rd_enb", 32'(ram_rd_enb), 32'(1));
      check("fs_addr", 32'(ram_addr), 32'(k));
      check("fs_valid", 32'(fetch_valid), 32'(k > 0));
      if (k > 0) check("fs_data", 32'(fetch_data), 32'(22'h00200));
    end
    drive(1'b0, 11'd0, 1'b0, 1'b0, 11'd0, 22'h0, 1'b0);
    check("fs_last_valid", 32'(fetch_valid), 32'(1));
    check("fs_last_data",  32'(fetch_data),  32'(22'h00200));
    check("fs_idle_rd",    32'(ram_rd_enb),  32'(0));
    drive(1'b0, 11'd0, 1'b0, 1'b0, 11'd0, 22'h0, 1'b0);
    check("fs_hold_valid", 32'(fetch_valid), 32'(0));
    check("fs_hold_data",  32'(fetch_data),  32'(22'h00200));

    // Halted CPU: loader write then read of address 200
    drive(1'b1, 11'd5, 1'b1, 1'b1, 11'd200, 22'h11111, 1'b1);
    check("halt_wr_gnt",   32'(ld_gnt),      32'(1));
    check("halt_wr_stall", 32'(fetch_stall), 32'(1));
    check("halt_wr_enb",   32'(ram_wr_enb),  32'(1));
    check("halt_wr_rd",    32'(ram_rd_enb),  32'(0));
    check("halt_wr_addr",  32'(ram_addr),    32'(200));
    check("halt_wr_data",  32'(ram_data_in), 32'(22'h11111));
    drive(1'b1, 11'd5, 1'b1, 1'b0, 11'd200, 22'h0, 1'b1);
    check("halt_rd_gnt",    32'(ld_gnt),     32'(1));
    check("halt_rd_enb",    32'(ram_rd_enb), 32'(1));
    check("halt_rd_wr",     32'(ram_wr_enb), 32'(0));
    check("halt_wr_norval", 32'(ld_rvalid),  32'(0));
    drive(1'b0, 11'd0, 1'b0, 1'b0, 11'd0, 22'h0, 1'b0);
    check("halt_rvalid",  32'(ld_rvalid),   32'(1));
    check("halt_rdata",   32'(ld_rdata),    32'(22'h11111));
    check("halt_fvalid",  32'(fetch_valid), 32'(0));

    // Starvation with STARVE_LIMIT=4: loader granted on cycle 5
    for (int i = 1; i <= 5; i++) begin
      logic e;
      e = (i == 5);
      drive(1'b1, 11'd1, 1'b1, 1'b0, 11'd200, 22'h0, 1'b0);
      check("starve_gnt",   32'(ld_gnt),      32'(e));
      check("starve_stall", 32'(fetch_stall), 32'(e));
      check("starve_addr",  32'(ram_addr),    e ? 32'(200) : 32'(1));
    end
    drive(1'b1, 11'd2, 1'b0, 1'b0, 11'd0, 22'h0, 1'b0);
    check("starve6_stall",  32'(fetch_stall), 32'(0));
    check("starve6_addr",   32'(ram_addr),    32'(2));
    check("starve6_rvalid", 32'(ld_rvalid),   32'(1));
    check("starve6_rdata",  32'(ld_rdata),    32'(22'h11111));
    check("starve6_fvalid", 32'(fetch_valid), 32'(0));
    drive(1'b1, 11'd3, 1'b1, 1'b0, 11'd200, 22'h0, 1'b0);
    check("cnt_cleared_gnt", 32'(ld_gnt),      32'(0));
    check("starve7_fvalid",  32'(fetch_valid), 32'(1));
    check("starve7_fdata",   32'(fetch_data),  32'(22'h00200));
    drive(1'b1, 11'd3, 1'b1, 1'b0, 11'd200, 22'h0, 1'b1);
    check("halt_mid_gnt",   32'(ld_gnt),      32'(1));
    check("halt_mid_stall", 32'(fetch_stall), 32'(1));

    // Out-of-range loader accesses
    drive(1'b0, 11'd0, 1'b1, 1'b1, 11'd1030, 22'h3ffff, 1'b0);
    check("oor_wr_gnt", 32'(ld_gnt),     32'(1));
    check("oor_wr_enb", 32'(ram_wr_enb), 32'(0));
    check("oor_wr_rd",  32'(ram_rd_enb), 32'(0));
    check("oor_wr_err_early", 32'(ld_err), 32'(0));
    drive(1'b0, 11'd0, 1'b1, 1'b0, 11'd1024, 22'h0, 1'b0);
    check("oor_rd_gnt",    32'(ld_gnt),     32'(1));
    check("oor_rd_enb",    32'(ram_rd_enb), 32'(0));
    check("oor_wr_err",    32'(ld_err),     32'(1));
    check("oor_wr_rvalid", 32'(ld_rvalid),  32'(0));
    drive(1'b0, 11'd0, 1'b0, 1'b0, 11'd0, 22'h0, 1'b0);
    check("oor_rd_err",    32'(ld_err),    32'(1));
    check("oor_rd_rvalid", 32'(ld_rvalid), 32'(1));
    check("oor_rd_rdata",  32'(ld_rdata),  32'(0));
    drive(1'b0, 11'd0, 1'b0, 1'b0, 11'd0, 22'h0, 1'b0);
    check("oor_err_end",    32'(ld_err),    32'(0));
    check("oor_rvalid_end", 32'(ld_rvalid), 32'(0));

    // Last valid address is in range
    drive(1'b0, 11'd0, 1'b1, 1'b1, 11'd1023, 22'h0abcd, 1'b0);
    check("edge_gnt",  32'(ld_gnt),     32'(1));
    check("edge_wr",   32'(ram_wr_enb), 32'(1));
    check("edge_addr", 32'(ram_addr),   32'(1023));
    drive(1'b0, 11'd0, 1'b0, 1'b0, 11'd0, 22'h0, 1'b0);
    check("edge_err", 32'(ld_err), 32'(0));

    // Fetch issued, then reset asserted before its data returns
    drive(1'b1, 11'd10, 1'b0, 1'b0, 11'd0, 22'h0, 1'b0);
    check("mid_rd_enb", 32'(ram_rd_enb), 32'(1));
    @(negedge clk);
    rst_n = 1'b0; fetch_req = 1'b0;
    #1;
    check("mid_rst_fvalid", 32'(fetch_valid), 32'(0));
    check("mid_rst_fdata",  32'(fetch_data),  32'(0));
    check("mid_rst_rvalid", 32'(ld_rvalid),   32'(0));
    check("mid_rst_rdata",  32'(ld_rdata),    32'(0));
    check("mid_rst_err",    32'(ld_err),      32'(0));
    check("mid_rst_rd",     32'(ram_rd_enb),  32'(0));
    check("mid_rst_busy",   32'(busy),        32'(SWEEP));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_fvalid", 32'(fetch_valid), 32'(0));
    @(negedge clk);
    #1;
    check("post_rst_fvalid2", 32'(fetch_valid), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
